// File: rtl/regfile_scoreboard.sv
// 32-entry architectural register file with two bypassed combinational read ports
// and a per-register busy scoreboard for long-latency producers.
module regfile_scoreboard #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_writeEnable,
  input  logic [4:0]       ctrl_writeReg,
  input  logic [WIDTH-1:0] data_writeReg,
  input  logic [4:0]       ctrl_readRegA,
  input  logic [4:0]       ctrl_readRegB,
  output logic [WIDTH-1:0] data_readRegA,
  output logic [WIDTH-1:0] data_readRegB,
  input  logic             mark_valid,
  input  logic [4:0]       mark_rd,
  output logic             busyA,
  output logic             busyB,
  output logic [5:0]       pending_count
);

  localparam int unsigned NREGS = 32;
  localparam int unsigned CNTW  = 6;

  logic [WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic [CNTW-1:0]  count_next;
  logic             wr_active;
  logic             mark_active;
  logic             hit_a;
  logic             hit_b;

  assign wr_active   = ctrl_writeEnable && (ctrl_writeReg != 5'd0);
  assign mark_active = mark_valid && (mark_rd != 5'd0);
  assign hit_a       = wr_active && (ctrl_writeReg == ctrl_readRegA);
  assign hit_b       = wr_active && (ctrl_writeReg == ctrl_readRegB);

  // Storage; entry 0 is never written so it holds its reset value of zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_active) begin
      regs[ctrl_writeReg] <= data_writeReg;
    end
  end

  // Read port A: zero register, then same-cycle writeback bypass, then storage.
  always_comb begin
    data_readRegA = regs[ctrl_readRegA];
    if (ctrl_readRegA == 5'd0) data_readRegA = '0;
    else if (hit_a)            data_readRegA = data_writeReg;
  end

  // Read port B: same resolution as port A.
  always_comb begin
    data_readRegB = regs[ctrl_readRegB];
    if (ctrl_readRegB == 5'd0) data_readRegB = '0;
    else if (hit_b)            data_readRegB = data_writeReg;
  end

  // Mark is applied after the clear so a new producer wins on the same index.
  always_comb begin
    busy_next = busy;
    if (wr_active)   busy_next[ctrl_writeReg] = 1'b0;
    if (mark_active) busy_next[mark_rd]       = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_comb begin
    count_next = '0;
    for (int i = 1; i < NREGS; i++) count_next = count_next + CNTW'(busy_next[i]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy          <= '0;
      pending_count <= '0;
    end else begin
      busy          <= busy_next;
      pending_count <= count_next;
    end
  end

  // A writeback in flight this cycle satisfies the operand through the bypass.
  assign busyA = busy[ctrl_readRegA] & ~hit_a;
  assign busyB = busy[ctrl_readRegB] & ~hit_b;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: storage, bypass, zero register, scoreboard and reset.
module tb_regfile_scoreboard;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_writeEnable = 1'b0;
  logic [4:0]  ctrl_writeReg = '0;
  logic [31:0] data_writeReg = '0;
  logic [4:0]  ctrl_readRegA = '0;
  logic [4:0]  ctrl_readRegB = '0;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;
  logic        mark_valid = 1'b0;
  logic [4:0]  mark_rd = '0;
  logic        busyA;
  logic        busyB;
  logic [5:0]  pending_count;

  int checks = 0;
  int errors = 0;

  regfile_scoreboard #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
    .mark_valid(mark_valid), .mark_rd(mark_rd),
    .busyA(busyA), .busyB(busyB), .pending_count(pending_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    ctrl_writeEnable = 1'b0;
    mark_valid = 1'b0;
  endtask

  task automatic test_reset();
    ctrl_readRegA = 5'd5;
    ctrl_readRegB = 5'd31;
    tick();
    tick();
    checks++; if (pending_count !== 6'd0) begin errors++; $display("FAIL reset_pending got %0d exp 0", pending_count); end
    checks++; if (data_readRegA !== 32'h0) begin errors++; $display("FAIL reset_readA got %h exp 0", data_readRegA); end
    checks++; if (busyB !== 1'b0) begin errors++; $display("FAIL reset_busyB got %b exp 0", busyB); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd5; data_writeReg = 32'hDEADBEEF;
    tick();
    idle();
    ctrl_readRegA = 5'd5; ctrl_readRegB = 5'd0;
    #1;
    checks++; if (data_readRegA !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_readA got %h exp deadbeef", data_readRegA); end
    checks++; if (data_readRegB !== 32'h0) begin errors++; $display("FAIL wr_readB0 got %h exp 0", data_readRegB); end
  endtask

  task automatic test_zero_reg();
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd0; data_writeReg = 32'h12345678;
    ctrl_readRegA = 5'd0;
    #1;
    checks++; if (data_readRegA !== 32'h0) begin errors++; $display("FAIL zero_nobypass got %h exp 0", data_readRegA); end
    tick();
    idle();
    #1;
    checks++; if (data_readRegA !== 32'h0) begin errors++; $display("FAIL zero_read got %h exp 0", data_readRegA); end
    mark_valid = 1'b1; mark_rd = 5'd0;
    tick();
    idle();
    #1;
    checks++; if (pending_count !== 6'd0) begin errors++; $display("FAIL zero_mark_pending got %0d exp 0", pending_count); end
    checks++; if (busyA !== 1'b0) begin errors++; $display("FAIL zero_mark_busy got %b exp 0", busyA); end
  endtask

  task automatic test_bypass();
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd7; data_writeReg = 32'h1;
    tick();
    idle();
    mark_valid = 1'b1; mark_rd = 5'd7;
    ctrl_readRegA = 5'd7; ctrl_readRegB = 5'd7;
    #1;
    checks++; if (busyA !== 1'b0) begin errors++; $display("FAIL mark_no_selfbypass got %b exp 0", busyA); end
    tick();
    idle();
    #1;
    checks++; if (pending_count !== 6'd1) begin errors++; $display("FAIL byp_pending1 got %0d exp 1", pending_count); end
    checks++; if (busyA !== 1'b1) begin errors++; $display("FAIL byp_busy_before got %b exp 1", busyA); end
    checks++; if (data_readRegA !== 32'h1) begin errors++; $display("FAIL byp_old got %h exp 1", data_readRegA); end
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd7; data_writeReg = 32'hABCD;
    #1;
    checks++; if (data_readRegA !== 32'hABCD) begin errors++; $display("FAIL byp_readA got %h exp abcd", data_readRegA); end
    checks++; if (data_readRegB !== 32'hABCD) begin errors++; $display("FAIL byp_readB got %h exp abcd", data_readRegB); end
    checks++; if (busyA !== 1'b0) begin errors++; $display("FAIL byp_busyA got %b exp 0", busyA); end
    checks++; if (busyB !== 1'b0) begin errors++; $display("FAIL byp_busyB got %b exp 0", busyB); end
    tick();
    idle();
    #1;
    checks++; if (pending_count !== 6'd0) begin errors++; $display("FAIL byp_pending0 got %0d exp 0", pending_count); end
    checks++; if (data_readRegA !== 32'hABCD) begin errors++; $display("FAIL byp_stored got %h exp abcd", data_readRegA); end
  endtask

  task automatic test_scoreboard();
    mark_valid = 1'b1; mark_rd = 5'd3;
    tick();
    checks++; if (pending_count !== 6'd1) begin errors++; $display("FAIL sb_count1 got %0d exp 1", pending_count); end
    mark_rd = 5'd4;
    tick();
    idle();
    checks++; if (pending_count !== 6'd2) begin errors++; $display("FAIL sb_count2 got %0d exp 2", pending_count); end
    ctrl_readRegA = 5'd3; ctrl_readRegB = 5'd4;
    #1;
    checks++; if (busyA !== 1'b1) begin errors++; $display("FAIL sb_busyA3 got %b exp 1", busyA); end
    checks++; if (busyB !== 1'b1) begin errors++; $display("FAIL sb_busyB4 got %b exp 1", busyB); end
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd3; data_writeReg = 32'h33;
    tick();
    idle();
    #1;
    checks++; if (pending_count !== 6'd1) begin errors++; $display("FAIL sb_count_after_wr got %0d exp 1", pending_count); end
    checks++; if (busyA !== 1'b0) begin errors++; $display("FAIL sb_busyA_clear got %b exp 0", busyA); end
    checks++; if (data_readRegA !== 32'h33) begin errors++; $display("FAIL sb_readA got %h exp 33", data_readRegA); end
    checks++; if (busyB !== 1'b1) begin errors++; $display("FAIL sb_busyB_kept got %b exp 1", busyB); end
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd4; data_writeReg = 32'h44;
    tick();
    idle();
    checks++; if (pending_count !== 6'd0) begin errors++; $display("FAIL sb_count_drain got %0d exp 0", pending_count); end
  endtask

  task automatic test_same_edge();
    mark_valid = 1'b1; mark_rd = 5'd9;
    tick();
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd9; data_writeReg = 32'h99;
    tick();
    idle();
    ctrl_readRegA = 5'd9;
    #1;
    checks++; if (pending_count !== 6'd1) begin errors++; $display("FAIL same_count got %0d exp 1", pending_count); end
    checks++; if (busyA !== 1'b1) begin errors++; $display("FAIL same_busy got %b exp 1", busyA); end
    checks++; if (data_readRegA !== 32'h99) begin errors++; $display("FAIL same_data got %h exp 99", data_readRegA); end
    mark_valid = 1'b1; mark_rd = 5'd9;
    tick();
    checks++; if (pending_count !== 6'd1) begin errors++; $display("FAIL remark_count got %0d exp 1", pending_count); end
    mark_rd = 5'd10;
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd9; data_writeReg = 32'h999;
    tick();
    idle();
    ctrl_readRegA = 5'd9; ctrl_readRegB = 5'd10;
    #1;
    checks++; if (pending_count !== 6'd1) begin errors++; $display("FAIL diff_count got %0d exp 1", pending_count); end
    checks++; if (busyA !== 1'b0) begin errors++; $display("FAIL diff_busy9 got %b exp 0", busyA); end
    checks++; if (busyB !== 1'b1) begin errors++; $display("FAIL diff_busy10 got %b exp 1", busyB); end
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd10; data_writeReg = 32'hA;
    tick();
    idle();
    checks++; if (pending_count !== 6'd0) begin errors++; $display("FAIL diff_drain got %0d exp 0", pending_count); end
  endtask

  task automatic test_mark_all_reset();
    for (int r = 1; r < 32; r++) begin
      mark_valid = 1'b1; mark_rd = 5'(r);
      tick();
      if (r == 16) begin
        checks++; if (pending_count !== 6'd16) begin errors++; $display("FAIL all_count16 got %0d exp 16", pending_count); end
      end
    end
    idle();
    checks++; if (pending_count !== 6'd31) begin errors++; $display("FAIL all_count31 got %0d exp 31", pending_count); end
    mark_valid = 1'b1; mark_rd = 5'd12;
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd12; data_writeReg = 32'hFFFF;
    ctrl_readRegA = 5'd12;
    #2;
    reset = 1'b1;
    #1;
    checks++; if (pending_count !== 6'd0) begin errors++; $display("FAIL async_count got %0d exp 0", pending_count); end
    checks++; if (data_readRegA !== 32'hFFFF) begin errors++; $display("FAIL rst_bypass got %h exp ffff", data_readRegA); end
    tick();
    reset = 1'b0;
    idle();
    tick();
    for (int r = 0; r < 32; r++) begin
      ctrl_readRegA = 5'(r); ctrl_readRegB = 5'(31 - r);
      #1;
      checks++; if (data_readRegA !== 32'h0 || busyA !== 1'b0) begin errors++; $display("FAIL post_rst_r%0d got %h busy %b exp 0", r, data_readRegA, busyA); end
      checks++; if (data_readRegB !== 32'h0 || busyB !== 1'b0) begin errors++; $display("FAIL post_rst_b%0d got %h busy %b exp 0", 31 - r, data_readRegB, busyB); end
    end
    checks++; if (pending_count !== 6'd0) begin errors++; $display("FAIL post_rst_count got %0d exp 0", pending_count); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_scoreboard();
    test_same_edge();
    test_mark_all_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
